// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: drives a req/ack data bus, stalls the pipeline while a
// transaction is outstanding, and returns aligned, extended load data.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mem_read,
    input  logic [1:0]  mem_write,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] mem_data,
    output logic        stall,
    output logic        access_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic [1:0]      ld_size;
    logic            ld_uns;
    logic [1:0]      ld_lane;

    logic            rd_op;
    logic            wr_op;
    logic [1:0]      op_size;
    logic            misaligned;
    logic            op_legal;
    logic            op_illegal;

    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b01:   return 4'b0001 << lane;
            2'b10:   return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b01:   return {4{data[7:0]}};
            2'b10:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                                input logic [1:0]  lane,
                                                input logic        uns,
                                                input logic [31:0] rdata);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = 8'(rdata >> {lane, 3'b000});
        h = 16'(rdata >> {lane[1], 4'b0000});
        case (size)
            2'b01:   return uns ? {24'b0, b} : 32'(b);
            2'b10:   return uns ? {16'b0, h} : 32'(h);
            default: return rdata;
        endcase
    endfunction

    assign rd_op      = |mem_read;
    assign wr_op      = |mem_write;
    assign op_size    = rd_op ? mem_read : mem_write;
    assign misaligned = ((op_size == 2'b10) && addr[0]) ||
                        ((op_size == 2'b11) && (addr[1:0] != 2'b00));
    assign op_legal   = (rd_op ^ wr_op) && !misaligned;
    assign op_illegal = (rd_op || wr_op) && !op_legal;
    assign cnt_next   = cnt + 1'b1;

    // Stall is combinational so a legal request freezes the pipeline in its issue cycle.
    assign stall = rst && (((state == IDLE) && op_legal) || (state == BUS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            ld_size      <= 2'b00;
            ld_uns       <= 1'b0;
            ld_lane      <= 2'b00;
            mem_data     <= 32'h0;
            access_fault <= 1'b0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= 32'h0;
            bus_wstrb    <= 4'h0;
            bus_wdata    <= 32'h0;
        end else begin
            access_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_legal) begin
                        bus_req   <= 1'b1;
                        bus_we    <= wr_op;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_wstrb <= wr_op ? store_strb(mem_write, addr[1:0]) : 4'h0;
                        bus_wdata <= store_lanes(mem_write, store_data);
                        ld_size   <= mem_read;
                        ld_uns    <= load_unsigned;
                        ld_lane   <= addr[1:0];
                        cnt       <= '0;
                        state     <= BUS;
                    end else if (op_illegal) begin
                        access_fault <= 1'b1;
                    end
                end
                BUS: begin
                    // An ack arriving on the limit cycle still wins over the timeout.
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we)
                            mem_data <= load_extend(ld_size, ld_lane, ld_uns, bus_rdata);
                        state <= DONE;
                    end else if (TIMEOUT_CYCLES > 0) begin
                        if (cnt_next == TO_LIM) begin
                            bus_req      <= 1'b0;
                            access_fault <= 1'b1;
                            state        <= DONE;
                        end else begin
                            cnt <= cnt_next;
                        end
                    end
                end
                DONE: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed reference memory model, bus slave with
// programmable ack delay, and a queue-based scoreboard checked by an independent monitor.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mem_read;
    logic [1:0]  mem_write;
    logic        load_unsigned;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] mem_data;
    logic        stall;
    logic        access_fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .load_unsigned(load_unsigned),
        .addr         (addr),
        .store_data   (store_data),
        .mem_data     (mem_data),
        .stall        (stall),
        .access_fault (access_fault),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wstrb    (bus_wstrb),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata)
    );

    always #5 clk = ~clk;

    // kind: 0 load completion, 1 store completion, 2 access fault
    typedef struct {
        int          kind;
        logic        we;
        logic [31:0] waddr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] md;
    } item_t;

    item_t       sbq[$];
    int          checks = 0;
    int          passes = 0;
    int          ack_delay = 0;
    logic [31:0] ref_md = 32'h0;
    logic [31:0] slv  [int unsigned];
    logic [7:0]  refb [int unsigned];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
    endtask

    function automatic logic [31:0] init_word(input int unsigned wa);
        return (wa * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] slv_word(input int unsigned wa);
        if (slv.exists(wa)) return slv[wa];
        return init_word(wa);
    endfunction

    function automatic logic [7:0] ref_byte(input int unsigned a);
        logic [31:0] w;
        if (refb.exists(a)) return refb[a];
        w = init_word(a >> 2);
        return 8'(w >> (8 * (a % 4)));
    endfunction

    task automatic poke(input int unsigned a, input logic [31:0] w);
        slv[a >> 2] = w;
        for (int i = 0; i < 4; i++) refb[(a & ~32'h3) + i] = 8'(w >> (8 * i));
    endtask

    // Bus slave: acks after ack_delay wait cycles, applies byte-enabled writes.
    initial begin : slave
        int          w;
        int unsigned wa;
        logic [31:0] word;
        w = 0;
        bus_ack = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (bus_req && !bus_ack) begin
                if (w >= ack_delay) begin
                    wa = bus_addr >> 2;
                    word = slv_word(wa);
                    if (bus_we) begin
                        for (int i = 0; i < 4; i++)
                            if (bus_wstrb[i]) word[8*i +: 8] = bus_wdata[8*i +: 8];
                        slv[wa] = word;
                        bus_rdata = $urandom;
                    end else begin
                        bus_rdata = word;
                    end
                    bus_ack = 1'b1;
                    w = 0;
                end else begin
                    w++;
                end
            end else begin
                bus_ack = 1'b0;
                w = 0;
            end
        end
    end

    // Monitor: checks bus fields on ack, result/fault on the following presentation.
    initial begin : monitor
        bit    pend;
        item_t it;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    pend = 1'b0;
                    it = sbq.pop_front();
                    chk("done_mem_data", mem_data, it.md);
                    chk("done_no_fault", 32'(access_fault), 32'h0);
                end else if (access_fault) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_fault", 32'h1, 32'h0);
                    end else begin
                        it = sbq.pop_front();
                        chk("fault_kind", 32'(it.kind), 32'd2);
                        chk("fault_mem_data", mem_data, it.md);
                    end
                end
                if (bus_req && bus_ack) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_ack", 32'h1, 32'h0);
                    end else begin
                        it = sbq[0];
                        chk("ack_expected_kind", 32'(it.kind == 2), 32'h0);
                        chk("bus_we", 32'(bus_we), 32'(it.we));
                        chk("bus_addr", bus_addr, it.waddr);
                        chk("bus_wstrb", 32'(bus_wstrb), 32'(it.wstrb));
                        if (it.we) chk("bus_wdata", bus_wdata, it.wdata);
                        pend = 1'b1;
                    end
                end
            end
        end
    end

    task automatic clear_inputs();
        mem_read = 2'b00;
        mem_write = 2'b00;
        load_unsigned = 1'b0;
        addr = 32'h0;
        store_data = 32'h0;
    endtask

    task automatic run_op(input logic [1:0] rd, input logic [1:0] wr, input logic uns,
                          input logic [31:0] a, input logic [31:0] sd, input int delay);
        int          n;
        bit          legal;
        bit          tmo;
        int          scnt;
        int          rcnt;
        logic [1:0]  size;
        logic [31:0] val;
        logic [31:0] base;
        item_t       it;
        size = (rd != 0) ? rd : wr;
        n = (size == 0) ? 1 : (1 << (size - 1));
        legal = ((rd != 0) != (wr != 0)) && ((a % n) == 0);
        tmo = (delay >= TO);
        base = a & ~32'h3;
        ack_delay = delay;
        @(posedge clk);
        #1;
        mem_read = rd;
        mem_write = wr;
        load_unsigned = uns;
        addr = a;
        store_data = sd;
        if (rd == 0 && wr == 0) begin
            @(negedge clk);
            chk("nop_stall", 32'(stall), 32'h0);
            chk("nop_bus_req", 32'(bus_req), 32'h0);
        end else if (!legal) begin
            it = '{kind: 2, we: 1'b0, waddr: 32'h0, wstrb: 4'h0, wdata: 32'h0, md: ref_md};
            sbq.push_back(it);
            @(negedge clk);
            chk("illegal_stall", 32'(stall), 32'h0);
            chk("illegal_bus_req", 32'(bus_req), 32'h0);
            @(posedge clk);
            #1;
            clear_inputs();
            @(negedge clk);
            @(negedge clk);
            chk("illegal_no_bus", 32'(bus_req), 32'h0);
        end else begin
            it.we = (wr != 0);
            it.waddr = base;
            it.wstrb = 4'h0;
            it.wdata = 32'h0;
            if (it.we)
                for (int i = 0; i < 4; i++) begin
                    if ((base + i) >= a && (base + i) < (a + n)) it.wstrb[i] = 1'b1;
                    it.wdata[8*i +: 8] = 8'(sd >> (8 * (i % n)));
                end
            if (tmo) begin
                it.kind = 2;
            end else if (it.we) begin
                it.kind = 1;
                for (int i = 0; i < n; i++) refb[a + i] = 8'(sd >> (8 * i));
            end else begin
                it.kind = 0;
                val = 32'h0;
                for (int i = 0; i < n; i++) val = val | (32'(ref_byte(a + i)) << (8 * i));
                if (!uns && n < 4 && val[8*n-1]) val = val | (~32'h0 << (8 * n));
                ref_md = val;
            end
            it.md = ref_md;
            sbq.push_back(it);
            scnt = 0;
            rcnt = 0;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (bus_req) rcnt++;
                if (stall) scnt++;
                else break;
            end
            chk("stall_cycles", 32'(scnt), tmo ? 32'(TO + 1) : 32'(delay + 2));
            chk("req_cycles", 32'(rcnt), tmo ? 32'(TO) : 32'(delay + 1));
            @(posedge clk);
            #1;
            clear_inputs();
        end
        clear_inputs();
    endtask

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [1:0]  rd;
        logic [1:0]  wr;
        int          r;
        int          d;
        rst = 1'b0;
        clear_inputs();
        #12;
        chk("rst_mem_data", mem_data, 32'h0);
        chk("rst_bus_req", 32'(bus_req), 32'h0);
        chk("rst_bus_we", 32'(bus_we), 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wstrb", 32'(bus_wstrb), 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_fault", 32'(access_fault), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        poke(32'h100, 32'hDEADBEEF);
        run_op(2'b11, 2'b00, 1'b0, 32'h100, 32'h0, 0);
        chk("word_load_0x100", mem_data, 32'hDEADBEEF);
        poke(32'h100, 32'h80FF1234);
        run_op(2'b01, 2'b00, 1'b0, 32'h103, 32'h0, 1);
        chk("byte_load_signed", mem_data, 32'hFFFFFF80);
        run_op(2'b01, 2'b00, 1'b1, 32'h103, 32'h0, 0);
        chk("byte_load_unsigned", mem_data, 32'h00000080);
        run_op(2'b10, 2'b00, 1'b0, 32'h102, 32'h0, 2);
        chk("half_load_signed", mem_data, 32'hFFFF80FF);
        run_op(2'b00, 2'b01, 1'b0, 32'h21, 32'h000000AB, 0);
        chk("store_keeps_mem_data", mem_data, 32'hFFFF80FF);
        run_op(2'b11, 2'b00, 1'b0, 32'h102, 32'h0, 0);
        run_op(2'b01, 2'b01, 1'b0, 32'h100, 32'h0, 0);
        run_op(2'b11, 2'b00, 1'b0, 32'h100, 32'h0, 255);
        chk("timeout_keeps_mem_data", mem_data, 32'hFFFF80FF);

        // Reset in the middle of a bus transaction that never gets acked.
        ack_delay = 255;
        @(posedge clk);
        #1;
        mem_read = 2'b11;
        addr = 32'h100;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_bus_req", 32'(bus_req), 32'h1);
        rst = 1'b0;
        #1;
        chk("async_rst_bus_req", 32'(bus_req), 32'h0);
        chk("async_rst_stall", 32'(stall), 32'h0);
        chk("async_rst_mem_data", mem_data, 32'h0);
        ref_md = 32'h0;
        @(posedge clk);
        #1;
        clear_inputs();
        rst = 1'b1;
        ack_delay = 0;
        poke(32'h100, 32'h13579BDF);
        run_op(2'b11, 2'b00, 1'b0, 32'h100, 32'h0, 0);
        chk("post_reset_word_load", mem_data, 32'h13579BDF);

        for (int t = 0; t < 200; t++) begin
            r = $urandom_range(0, 9);
            rd = 2'b00;
            wr = 2'b00;
            if (r < 4) rd = 2'($urandom_range(1, 3));
            else if (r < 8) wr = 2'($urandom_range(1, 3));
            else if (r == 8) begin
                rd = 2'($urandom_range(1, 3));
                wr = 2'($urandom_range(1, 3));
            end
            d = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 2);
            run_op(rd, wr, 1'($urandom_range(0, 1)), 32'h200 + $urandom_range(0, 31), $urandom, d);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage block that executes loads and stores for the pipeline over a req/ack data bus.
- Produces the aligned, sign/zero-extended mem_data that the writeback stage selects when mem_read is nonzero.
- Stalls the pipeline while a bus transaction is outstanding.
- Flags misaligned or illegal accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in BUS without bus_ack before abort; 0 disables the timeout. Counter width is clog2(TIMEOUT_CYCLES+1), minimum 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous assert, active-low (0 = reset)
- mem_read  in  2  load size: 00 none, 01 byte, 10 half, 11 word
- mem_write  in  2  store size, same encoding as mem_read
- load_unsigned  in  1  1 = zero-extend byte/half loads
- addr  in  32  byte address of the access
- store_data  in  32  store data, right-aligned
- mem_data  out  32  extended load result
- stall  out  1  hold pipeline; inputs stay stable while 1
- access_fault  out  1  one-cycle pulse on a misaligned, illegal or timed-out access
- bus_req  out  1  transaction request
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, {addr[31:2],2'b00}
- bus_wstrb  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  transaction complete; bus_rdata valid in the same cycle
- bus_rdata  in  32  read word

Behaviour:
- Reset values: state IDLE, mem_data 0, bus_req 0, bus_we 0, bus_addr 0, bus_wstrb 0, bus_wdata 0, access_fault 0, timeout counter 0. stall is combinational and reads 0 in reset.
- Asserting reset mid-transaction drops bus_req immediately and abandons the access; no completion occurs.
- States: IDLE, BUS, DONE.
- IDLE, no operation (mem_read==0 and mem_write==0): stall=0, no bus activity.
- IDLE, legal operation: stall=1 combinationally in the same cycle. Register bus fields and go to BUS.
- Legal means exactly one of mem_read/mem_write is nonzero, and the access is aligned: half needs addr[0]==0; word needs addr[1:0]==0.
- IDLE, illegal operation (both nonzero, or misaligned): no bus traffic, stall=0, access_fault=1 for the next cycle only, state remains IDLE. mem_data is unchanged.
- BUS: bus_req=1. bus_we, bus_addr, bus_wstrb and bus_wdata are held constant until ack. stall=1.
- BUS, bus_ack=1: drop bus_req next cycle, go to DONE.
  - Load: register the extended result into mem_data on that edge.
  - Store: mem_data is unchanged.
- BUS timeout: if TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES without ack, drop bus_req, pulse access_fault, go to DONE. mem_data is unchanged.
- DONE: stall=0 for exactly one cycle so the pipeline advances. Return to IDLE. A new operation is never launched from DONE.
- Minimum latency for a legal access is 3 cycles (IDLE, BUS with immediate ack, DONE); stall is high for 2 of them.
- Load extraction, lane = addr[1:0]:
  - Byte: rdata[8*lane+7 : 8*lane].
  - Half: rdata[16*addr[1]+15 : 16*addr[1]].
  - Sign-extend from bit 7 or 15 unless load_unsigned. Word loads pass through unchanged.
- Store encoding:
  - Byte: wstrb = 4'b0001<<lane, wdata = {4{store_data[7:0]}}.
  - Half: wstrb = 4'b0011<<lane, wdata = {2{store_data[15:0]}}.
  - Word: wstrb = 4'b1111, wdata = store_data.
- bus_wstrb=0 and bus_wdata are don't-care for reads.
- mem_data holds its last load value indefinitely.

Test Plan:
- Word load at addr 0x100, bus_ack one cycle after req, bus_rdata 0xDEADBEEF:
  - bus_addr 0x100, bus_we=0.
  - mem_data=0xDEADBEEF in the DONE cycle.
  - stall high for 2 cycles, access_fault never asserted.
- Byte load at addr 0x103, rdata 0x80FF1234:
  - load_unsigned=0 -> mem_data 0xFFFFFF80.
  - load_unsigned=1 -> 0x00000080.
  - Half load at 0x102, signed -> 0xFFFF80FF.
- Byte store at addr 0x21, store_data 0x000000AB:
  - bus_addr 0x20, bus_we=1, bus_wstrb 0010, bus_wdata 0xABABABAB.
  - mem_data unchanged.
- Word load at addr 0x102 -> no bus_req, stall=0, access_fault pulse one cycle. The same holds for mem_read=01 with mem_write=01 together.
- TIMEOUT_CYCLES=4, bus_ack never asserted -> bus_req high for 4 cycles then low, access_fault pulses once, stall released after DONE, mem_data unchanged.
- rst driven low while in BUS -> bus_req low asynchronously. After release, a fresh word load completes normally with mem_data correct.
